// File: rtl/reg_check_engine_if.sv
// Signal bundle for reg_check_engine: run control, expected-value table
// configuration, register-file debug read port and check results.
// The engine connects through the slave modport and the driving system
// through the master modport.
interface reg_check_engine_if #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 16
);
  localparam int IdxW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int FcW  = $clog2(NUM_CHECKS + 1);

  logic            start;
  logic            halt;
  logic            cfg_we;
  logic [IdxW-1:0] cfg_idx;
  logic            cfg_valid;
  logic [4:0]      cfg_reg;
  logic [XLEN-1:0] cfg_val;
  logic [XLEN-1:0] cfg_mask;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            busy;
  logic            done;
  logic            pass;
  logic [FcW-1:0]  fail_count;
  logic [IdxW-1:0] first_fail_idx;
  logic [XLEN-1:0] first_fail_data;

  modport master (
    output start, halt, cfg_we, cfg_idx, cfg_valid, cfg_reg, cfg_val, cfg_mask,
    output rf_rdata,
    input  rf_raddr, busy, done, pass, fail_count, first_fail_idx, first_fail_data
  );

  modport slave (
    input  start, halt, cfg_we, cfg_idx, cfg_valid, cfg_reg, cfg_val, cfg_mask,
    input  rf_rdata,
    output rf_raddr, busy, done, pass, fail_count, first_fail_idx, first_fail_data
  );
endinterface

// File: rtl/reg_check_engine.sv
// Register check engine: lets a CPU program run for a bounded number of
// cycles (or until it halts), then walks a table of expected register values,
// reading each register through the register-file debug port and comparing
// under a per-entry mask. Reports pass/fail, a saturating fail count and the
// index and read data of the first failing entry.
module reg_check_engine #(
  parameter int XLEN       = 32,
  parameter int NUM_CHECKS = 16,
  parameter int RUN_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  reg_check_engine_if.slave bus_io
);
  localparam int IdxW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int FcW  = $clog2(NUM_CHECKS + 1);
  localparam int CntW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    ADDR,
    CMP,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [4:0]      raddr_q, raddr_d;
  logic [FcW-1:0]  fail_q, fail_d;
  logic [IdxW-1:0] ffidx_q, ffidx_d;
  logic [XLEN-1:0] ffdata_q, ffdata_d;

  logic            valid_q [NUM_CHECKS];
  logic [4:0]      reg_q   [NUM_CHECKS];
  logic [XLEN-1:0] val_q   [NUM_CHECKS];
  logic [XLEN-1:0] mask_q  [NUM_CHECKS];

  logic            busy;
  logic            mismatch;
  logic            first_found;
  logic [IdxW-1:0] first_idx;
  logic            next_found;
  logic [IdxW-1:0] next_idx;

  assign busy     = (state_q == RUN) || (state_q == ADDR) || (state_q == CMP);
  assign mismatch = |((bus_io.rf_rdata ^ val_q[idx_q]) & mask_q[idx_q]);

  // Find the lowest valid entry overall and the lowest valid entry after the current one
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (valid_q[i]) begin
        first_found = 1'b1;
        first_idx   = IdxW'(i);
      end
      if (valid_q[i] && (i > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = IdxW'(i);
      end
    end
  end

  // Next-state logic: run phase, then one ADDR/CMP pair per valid entry
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    raddr_d  = raddr_q;
    fail_d   = fail_q;
    ffidx_d  = ffidx_q;
    ffdata_d = ffdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus_io.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          fail_d   = '0;
          ffidx_d  = '0;
          ffdata_d = '0;
        end
      end
      RUN: begin
        if (bus_io.halt || (cnt_q == CntW'(RUN_CYCLES - 1))) begin
          if (first_found) begin
            state_d = ADDR;
            idx_d   = first_idx;
            raddr_d = reg_q[first_idx];
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADDR: begin
        state_d = CMP;
      end
      CMP: begin
        if (mismatch) begin
          if (fail_q != FcW'(NUM_CHECKS)) begin
            fail_d = fail_q + 1'b1;
          end
          if (fail_q == '0) begin
            ffidx_d  = idx_q;
            ffdata_d = bus_io.rf_rdata;
          end
        end
        if (next_found) begin
          state_d = ADDR;
          idx_d   = next_idx;
          raddr_d = reg_q[next_idx];
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      raddr_q  <= '0;
      fail_q   <= '0;
      ffidx_q  <= '0;
      ffdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      raddr_q  <= raddr_d;
      fail_q   <= fail_d;
      ffidx_q  <= ffidx_d;
      ffdata_q <= ffdata_d;
    end
  end

  // Expected-value table; writes are locked out while a run is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        valid_q[i] <= 1'b0;
        reg_q[i]   <= '0;
        val_q[i]   <= '0;
        mask_q[i]  <= '0;
      end
    end else if (bus_io.cfg_we && !busy && (int'(bus_io.cfg_idx) < NUM_CHECKS)) begin
      valid_q[bus_io.cfg_idx] <= bus_io.cfg_valid;
      reg_q[bus_io.cfg_idx]   <= bus_io.cfg_reg;
      val_q[bus_io.cfg_idx]   <= bus_io.cfg_val;
      mask_q[bus_io.cfg_idx]  <= bus_io.cfg_mask;
    end
  end

  assign bus_io.rf_raddr        = raddr_q;
  assign bus_io.busy            = busy;
  assign bus_io.done            = (state_q == DONE);
  assign bus_io.pass            = (state_q == DONE) && (fail_q == '0);
  assign bus_io.fail_count      = fail_q;
  assign bus_io.first_fail_idx  = ffidx_q;
  assign bus_io.first_fail_data = ffdata_q;
endmodule

// File: tb/tb_reg_check_engine.sv
// Self-checking bench for reg_check_engine: directed scenarios followed by
// randomized tables and register-file contents, each run predicted by a
// behavioural model of the expected-value check.
`timescale 1ns/1ps
module tb_reg_check_engine;
  localparam int XLEN       = 32;
  localparam int NUM_CHECKS = 16;
  localparam int RUN_CYCLES = 100;
  localparam int TIMEOUT    = 400;
  localparam int IdxW       = $clog2(NUM_CHECKS);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] rf     [32];
  bit          mValid [NUM_CHECKS];
  logic [4:0]  mReg   [NUM_CHECKS];
  logic [31:0] mVal   [NUM_CHECKS];
  logic [31:0] mMask  [NUM_CHECKS];

  reg_check_engine_if #(.XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS)) bus ();

  reg_check_engine #(
    .XLEN(XLEN), .NUM_CHECKS(NUM_CHECKS), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  // Clock generator
  always #5 clk = ~clk;

  // Register-file model: read data valid one cycle after the address
  always @(posedge clk) bus.rf_rdata <= rf[bus.rf_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic writeEntry(input int idx, input bit v, input logic [4:0] r,
                            input logic [31:0] val, input logic [31:0] mask);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IdxW'(idx);
    bus.cfg_valid = v;
    bus.cfg_reg   = r;
    bus.cfg_val   = val;
    bus.cfg_mask  = mask;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    mValid[idx] = v;
    mReg[idx]   = r;
    mVal[idx]   = val;
    mMask[idx]  = mask;
  endtask

  task automatic clearTable();
    for (int i = 0; i < NUM_CHECKS; i++) writeEntry(i, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Expected outcome of a run from the table, the RF contents and the halt point
  task automatic predict(input int haltAt, output int lat, output int nFail, output int ffIdx,
                         output logic [31:0] ffData, output int firstReg, output int runLen);
    int nValid;
    nValid   = 0;
    runLen   = (haltAt > 0 && haltAt < RUN_CYCLES) ? haltAt : RUN_CYCLES;
    nFail    = 0;
    ffIdx    = 0;
    ffData   = 32'd0;
    firstReg = -1;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (mValid[i]) begin
        if (firstReg < 0) firstReg = int'(mReg[i]);
        nValid++;
        if (((rf[mReg[i]] ^ mVal[i]) & mMask[i]) != 32'd0) begin
          if (nFail == 0) begin
            ffIdx  = i;
            ffData = rf[mReg[i]];
          end
          nFail++;
        end
      end
    end
    if (nFail > NUM_CHECKS) nFail = NUM_CHECKS;
    lat = runLen + 2 * nValid;
  endtask

  // One run: start pulse, optional halt, optional stray start/table write, then result checks
  task automatic applyStimulus(input int haltAt, input int restartAt, input bit cfgInCmp);
    int lat, nFail, ffIdx, firstReg, runLen, edges;
    logic [31:0] ffData;
    predict(haltAt, lat, nFail, ffIdx, ffData, firstReg, runLen);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busyInRun", bus.busy, 1);
    checkOutput("doneClearedByStart", bus.done, 0);
    edges = 0;
    while (!bus.done && edges < TIMEOUT) begin
      bus.halt  = (edges + 1 == haltAt);
      bus.start = (edges + 1 == restartAt);
      if (cfgInCmp && firstReg >= 0 && (edges + 1 == runLen + 2)) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = '0;
        bus.cfg_valid = 1'b1;
        bus.cfg_reg   = mReg[0];
        bus.cfg_val   = ~rf[mReg[0]];
        bus.cfg_mask  = '1;
      end
      @(posedge clk); #1;
      edges++;
      bus.halt   = 1'b0;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      if (firstReg >= 0 && edges == runLen) checkOutput("firstAddr", {27'd0, bus.rf_raddr}, firstReg);
    end
    checkOutput("doneLatency", edges, lat);
    checkOutput("busyInDone", bus.busy, 0);
    checkOutput("pass", bus.pass, (nFail == 0));
    checkOutput("failCount", bus.fail_count, nFail);
    checkOutput("firstFailIdx", bus.first_fail_idx, ffIdx);
    checkOutput("firstFailData", bus.first_fail_data, ffData);
  endtask

  // Abort a run with reset at its first CMP cycle, then reset while start and a table write are asserted
  task automatic abortAndReset();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (RUN_CYCLES + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortDone", bus.done, 0);
    checkOutput("abortFailCount", bus.fail_count, 0);
    checkOutput("abortRaddr", {27'd0, bus.rf_raddr}, 0);
    for (int i = 0; i < NUM_CHECKS; i++) mValid[i] = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IdxW'(3);
    bus.cfg_valid = 1'b1;
    bus.cfg_reg   = 5'd4;
    bus.cfg_val   = ~rf[4];
    bus.cfg_mask  = '1;
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    checkOutput("rstOverStartBusy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("noDoneAfterAbort", bus.done, 0);
  endtask

  initial begin
    logic [4:0]  rg;
    logic [31:0] v, m;
    bit          en;
    int          h;
    bus.start     = 1'b0;
    bus.halt      = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_reg   = '0;
    bus.cfg_val   = '0;
    bus.cfg_mask  = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < NUM_CHECKS; i++) mValid[i] = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstPass", bus.pass, 0);
    checkOutput("rstFailCount", bus.fail_count, 0);
    checkOutput("rstFirstFailIdx", bus.first_fail_idx, 0);
    checkOutput("rstFirstFailData", bus.first_fail_data, 0);
    checkOutput("rstRaddr", {27'd0, bus.rf_raddr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] all-matching table of three entries");
    rf[10] = 32'd1;
    rf[11] = 32'h8000_0000;
    rf[12] = 32'd301;
    writeEntry(0, 1'b1, 5'd10, 32'd1, '1);
    writeEntry(1, 1'b1, 5'd11, 32'h8000_0000, '1);
    writeEntry(2, 1'b1, 5'd12, 32'd301, '1);
    applyStimulus(0, 0, 1'b0);

    $display("[TB] single mismatching entry");
    writeEntry(1, 1'b1, 5'd12, 32'd302, '1);
    applyStimulus(0, 0, 1'b0);

    $display("[TB] early halt with one valid entry");
    clearTable();
    writeEntry(0, 1'b1, 5'd12, 32'd301, '1);
    applyStimulus(5, 0, 1'b0);

    $display("[TB] partial mask and x0 entry");
    rf[7] = 32'hFFFF_04D3;
    rf[0] = 32'hDEAD_BEEF;
    writeEntry(0, 1'b1, 5'd7, 32'h1234_04D3, 32'h0000_FFFF);
    writeEntry(1, 1'b1, 5'd0, 32'hDEAD_BEEF, '1);
    writeEntry(2, 1'b1, 5'd11, 32'h0, 32'h0);
    applyStimulus(0, 0, 1'b0);

    $display("[TB] stray start in RUN and table write in CMP");
    applyStimulus(0, 50, 1'b1);
    applyStimulus(0, 0, 1'b0);

    $display("[TB] reset mid-run");
    abortAndReset();
    applyStimulus(0, 0, 1'b0);

    $display("[TB] randomized runs");
    for (int t = 0; t < 12; t++) begin
      for (int r = 0; r < 32; r++) rf[r] = $urandom;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        en = ($urandom_range(0, 3) != 0) && (t != 3);
        rg = 5'($urandom_range(0, 31));
        v  = ($urandom_range(0, 2) == 0) ? (rf[rg] ^ (32'h1 << $urandom_range(0, 31))) : rf[rg];
        case ($urandom_range(0, 3))
          0:       m = '1;
          1:       m = 32'h0;
          2:       m = 32'h0000_FFFF;
          default: m = $urandom;
        endcase
        writeEntry(i, en, rg, v, m);
      end
      h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RUN_CYCLES + 3)) : 0;
      applyStimulus(h, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_check_engine.md
REG_CHECK_ENGINE -- requirements
Module: reg_check_engine

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width.
REQ-002 SHALL have parameter NUM_CHECKS, default 16, number of expected-value table entries (1..64).
REQ-003 SHALL have parameter RUN_CYCLES, default 100, cycles allowed for the program before checking starts (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a run.
REQ-007 SHALL have port halt  input  1  CPU halted; ends the run phase early.
REQ-008 SHALL have port cfg_we  input  1  table write strobe.
REQ-009 SHALL have port cfg_idx  input  $clog2(NUM_CHECKS)  table entry index.
REQ-010 SHALL have ports cfg_valid (1), cfg_reg (5), cfg_val (XLEN) and cfg_mask (XLEN), all inputs: entry enable, register index, expected value and compare mask.
REQ-011 SHALL have port rf_raddr  output  5  register-file debug read address.
REQ-012 SHALL have port rf_rdata  input  XLEN  register-file debug read data, valid one cycle after rf_raddr.
REQ-013 SHALL have ports busy (1), done (1) and pass (1), all outputs: run in progress, result valid, all checks matched.
REQ-014 SHALL have outputs fail_count ($clog2(NUM_CHECKS+1)), first_fail_idx ($clog2(NUM_CHECKS)) and first_fail_data (XLEN).

Function
REQ-015 SHALL implement states IDLE, RUN, ADDR, CMP, DONE.
REQ-016 SHALL write table entry cfg_idx on cfg_we in any state except RUN/ADDR/CMP, where cfg_we is ignored.
REQ-017 IDLE/DONE: start=1 -> RUN next cycle; cycle counter, fail_count, pass, done and first_fail_* are cleared on that edge.
REQ-018 RUN: counter increments each cycle; -> ADDR after RUN_CYCLES cycles in RUN, or on the cycle after halt=1, whichever comes first.
REQ-019 ADDR: drive rf_raddr=cfg_reg of the current entry, -> CMP; entries with valid=0 are skipped without spending an ADDR/CMP pair.
REQ-020 CMP: the entry fails iff (rf_rdata ^ val) & mask != 0; on a failure fail_count increments, and first failure only latches first_fail_idx and first_fail_data=rf_rdata.
REQ-021 After the last entry's CMP (or immediately from RUN if no entry is valid) -> DONE.
REQ-022 DONE: done=1, pass=(fail_count==0), busy=0; held until next start or rst.
REQ-023 busy SHALL be 1 exactly in RUN, ADDR and CMP.
REQ-024 start while busy SHALL be ignored.
REQ-025 Check latency SHALL be 2 cycles per valid entry after RUN ends.
REQ-026 mask=0 entry SHALL always pass; x0 entries are checked like any other register.
REQ-027 fail_count SHALL saturate at NUM_CHECKS (no wrap).

Reset
REQ-028 rst=1 SHALL force IDLE and set busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, first_fail_data=0, rf_raddr=0, counter=0, all cfg_valid=0; rst overrides start and cfg_we in the same cycle.
REQ-029 rst asserted mid-run SHALL abort the run with no done pulse.

Verification
REQ-030 Load entries {x10=1, x11=0x80000000, x12=301}, mask all-ones, matching RF, start -> done after 100+6 cycles, pass=1, fail_count=0.
REQ-031 Entry 1 expects 302 and RF holds 301 -> pass=0, fail_count=1, first_fail_idx=1, first_fail_data=301.
REQ-032 halt=1 at cycle 5 of RUN with 1 valid entry -> ADDR at cycle 6, done at cycle 8 after start.
REQ-033 Mask 0x0000FFFF, expected 0x1234_04D3, RF 0xFFFF_04D3 -> pass=1.
REQ-034 rst at the first CMP cycle -> IDLE next cycle, busy=0, done=0, table cleared; new start with no entries -> done after RUN_CYCLES+1 cycles, pass=1.
REQ-035 start pulsed during RUN and cfg_we during CMP -> no restart and table unchanged.
